// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and widths for the FP16 multiplier arbiter.
//   FP_W       - packed FP16 operand width
//   PROD_W     - multiplier result fraction width
//   arb_state_t - arbiter FSM states
//   mul_rsp_t  - registered response (product + flags)
package mul_arb_pkg;

  localparam int FP_W   = 16;
  localparam int PROD_W = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [PROD_W-1:0] product;
    logic              carry;
    logic              round_loss;
  } mul_rsp_t;

  // Zero magnitude regardless of sign (+0 / -0).
  function automatic logic fp16_is_zero(input logic [FP_W-1:0] x);
    return (x[FP_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// mul_rr_pick: combinational round-robin picker.
//   req  [NREQ] - request vector
//   ptr  [PW]   - highest-priority index this round
//   gnt  [NREQ] - one-hot grant (zero when no request)
//   idx  [PW]   - index of the granted requester
//   any         - at least one request present
module mul_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic          hi_any;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Two-pass priority: lowest requester at or above ptr wins; otherwise the
  // lowest requester below ptr (wrap-around). Scanning downward lets the last
  // write land on the lowest index.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = PW'(i);
        end else begin
          lo_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    any      = |req;
    idx      = hi_any ? hi_idx : lo_idx;
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multicycle FP16 multiplier
// between NREQ requesters. One operation in flight; IDLE->ISSUE->WAIT->RESP.
//   clk, RST (sync, active-high)
//   req_valid/req_ready [NREQ]     - per-requester handshake, ready one-hot
//   req_fp1/req_fp2 [NREQ*16]      - packed operands, lane i at [16i+15:16i]
//   mul_active, mul_fp1, mul_fp2   - multiplier start pulse and operands
//   mul_product, mul_carry, mul_round_loss - multiplier result inputs
//   rsp_valid [NREQ]               - one-hot response strobe
//   rsp_product, rsp_carry, rsp_round_loss - held registered result
//   busy                           - high outside IDLE
// Optional: `define MUL_ARB_ZERO_BYPASS_EN to answer pairs with a zero
// operand directly (result 0, no multiplier use).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 15
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*FP_W-1:0]   req_fp1,
  input  logic [NREQ*FP_W-1:0]   req_fp2,
  output logic                   mul_active,
  output logic [FP_W-1:0]        mul_fp1,
  output logic [FP_W-1:0]        mul_fp2,
  input  logic [PROD_W-1:0]      mul_product,
  input  logic                   mul_carry,
  input  logic                   mul_round_loss,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]      rsp_product,
  output logic                   rsp_carry,
  output logic                   rsp_round_loss,
  output logic                   busy
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  arb_state_t state, state_nxt;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_q;
  logic [FP_W-1:0] op1_q, op2_q;
  logic [WCW-1:0]  wait_cnt;
  mul_rsp_t        rsp_q;

  logic [NREQ-1:0][FP_W-1:0] fp1_lanes, fp2_lanes;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [FP_W-1:0] sel_fp1, sel_fp2;

  logic accept;
  logic capture;
`ifdef MUL_ARB_ZERO_BYPASS_EN
  logic bypass;
`endif

  assign fp1_lanes = req_fp1;
  assign fp2_lanes = req_fp2;
  assign sel_fp1   = fp1_lanes[pick_idx];
  assign sel_fp2   = fp2_lanes[pick_idx];

  mul_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
`ifdef MUL_ARB_ZERO_BYPASS_EN
    bypass     = 1'b0;
`endif
    mul_active = 1'b0;
    mul_fp1    = '0;
    mul_fp2    = '0;
    rsp_valid  = '0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // No accept during reset: the grant would be lost at the edge while
        // the requester believed it was taken.
        if (pick_any && !RST) begin
          req_ready = pick_gnt;
          accept    = 1'b1;
          state_nxt = S_ISSUE;
`ifdef MUL_ARB_ZERO_BYPASS_EN
          if (fp16_is_zero(sel_fp1) || fp16_is_zero(sel_fp2)) begin
            bypass    = 1'b1;
            state_nxt = S_RESP;
          end
`endif
        end
      end
      S_ISSUE: begin
        mul_active = 1'b1;
        mul_fp1    = op1_q;
        mul_fp2    = op2_q;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        mul_fp1 = op1_q;
        mul_fp2 = op2_q;
        if (wait_cnt == WCW'(LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rr_ptr   <= '0;
      gnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      wait_cnt <= '0;
      rsp_q    <= '0;
    end else begin
      if (accept) begin
        gnt_q <= pick_idx;
        op1_q <= sel_fp1;
        op2_q <= sel_fp2;
      end
      // Counts only while waiting; anything else parks it at zero so the
      // next WAIT always starts from 0.
      if (state == S_WAIT && !capture) wait_cnt <= wait_cnt + WCW'(1);
      else                             wait_cnt <= '0;
      if (capture) begin
        rsp_q.product    <= mul_product;
        rsp_q.carry      <= mul_carry;
        rsp_q.round_loss <= mul_round_loss;
      end
`ifdef MUL_ARB_ZERO_BYPASS_EN
      else if (bypass) begin
        rsp_q <= '0;
      end
`endif
      if (state == S_RESP)
        rr_ptr <= (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
    end
  end

  assign rsp_product    = rsp_q.product;
  assign rsp_carry      = rsp_q.carry;
  assign rsp_round_loss = rsp_q.round_loss;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: self-checking bench for mul_arbiter. A timeline model
// (grant cycle -> active/operand window/response cycle) predicts every output
// each cycle; a multiplier stub answers exactly LAT cycles after mul_active
// and drives noise otherwise. Honors `MUL_ARB_ZERO_BYPASS_EN like the DUT.
module tb_mul_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 15;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [NREQ-1:0] rv = '0, cont = '0;
  logic [NREQ-1:0][15:0] f1 = '0, f2 = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic mul_active, rsp_carry, rsp_round_loss, busy;
  logic [15:0] mul_fp1, mul_fp2;
  logic [12:0] mul_product = '0;
  logic [12:0] rsp_product;
  logic mul_carry = 1'b0, mul_round_loss = 1'b0;

  int rate = 0, drop = 0, zmix = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .RST(RST),
    .req_valid(rv), .req_ready(req_ready),
    .req_fp1(f1), .req_fp2(f2),
    .mul_active(mul_active), .mul_fp1(mul_fp1), .mul_fp2(mul_fp2),
    .mul_product(mul_product), .mul_carry(mul_carry), .mul_round_loss(mul_round_loss),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_carry(rsp_carry), .rsp_round_loss(rsp_round_loss),
    .busy(busy)
  );

  // Reference multiplier: {product[12:0], carry, round_loss} from mantissas.
  function automatic logic [14:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    return {p[20:8], p[21], |p[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- multiplier stub ----------------
  int s_rem = -1;
  logic [14:0] s_val = '0;
  always @(negedge clk) begin
    if (s_rem > 0) s_rem--;
    if (mul_active) begin
      s_rem = LAT;
      s_val = fmul(mul_fp1, mul_fp2);
    end
    if (s_rem == 0) begin
      {mul_product, mul_carry, mul_round_loss} = s_val;
      s_rem = -1;
    end else begin
      {mul_product, mul_carry, mul_round_loss} = 15'($urandom);
    end
    if (RST) s_rem = -1;
  end

  // ---------------- timeline model + compare ----------------
  int cyc = 0, m_ptr = 0, m_idle = 0, m_acc = -1, m_act = -1, m_rsp = -1, m_g = 0;
  logic [15:0] m_op1 = '0, m_op2 = '0;
  logic [14:0] m_res = '0, m_hold = '0;
  logic [NREQ-1:0] last_rdy = '0;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy, e_rsp;
    logic e_act, e_fp, e_busy, zero;
    int g;
    cyc++;
    e_rdy = '0;
    e_rsp = '0;
    if (cyc == m_rsp) begin
      m_hold     = m_res;
      e_rsp[m_g] = 1'b1;
      m_ptr      = (m_g + 1) % NREQ;
    end
    if (!RST && cyc >= m_idle && rv != '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      e_rdy[g] = 1'b1;
      m_g   = g;
      m_acc = cyc;
      m_op1 = f1[g];
      m_op2 = f2[g];
      zero  = 1'b0;
`ifdef MUL_ARB_ZERO_BYPASS_EN
      zero  = (m_op1[14:0] == 15'd0) || (m_op2[14:0] == 15'd0);
`endif
      if (zero) begin
        m_act = -1;
        m_rsp = cyc + 1;
        m_res = '0;
      end else begin
        m_act = cyc + 1;
        m_rsp = cyc + LAT + 2;
        m_res = fmul(m_op1, m_op2);
      end
      m_idle = m_rsp + 1;
    end
    e_act  = (cyc == m_act);
    e_fp   = (m_act >= 0 && cyc >= m_act && cyc <= m_act + LAT);
    e_busy = (m_acc >= 0 && cyc > m_acc && cyc <= m_rsp);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("mul_active", 32'(mul_active), 32'(e_act));
    chk("mul_fp1", 32'(mul_fp1), e_fp ? 32'(m_op1) : 32'd0);
    chk("mul_fp2", 32'(mul_fp2), e_fp ? 32'(m_op2) : 32'd0);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rsp_product", 32'(rsp_product), 32'(m_hold[14:2]));
    chk("rsp_carry", 32'(rsp_carry), 32'(m_hold[1]));
    chk("rsp_round_loss", 32'(rsp_round_loss), 32'(m_hold[0]));
    last_rdy = req_ready;
    if (RST) begin
      m_ptr  = 0;
      m_idle = cyc + 1;
      m_acc  = -1;
      m_act  = -1;
      m_rsp  = -1;
      m_hold = '0;
    end
  end

  // ---------------- requesters ----------------
  function automatic logic [15:0] rnd_op();
    if (zmix != 0) begin
      case ($urandom_range(0, 7))
        0:       return 16'h0000;
        1:       return 16'h8000;
        default: return 16'($urandom);
      endcase
    end
    return 16'($urandom) | 16'h0400;
  endfunction

  task automatic new_ops(input int i);
    f1[i] = rnd_op();
    f2[i] = rnd_op();
  endtask

  // Requesters hold valid+operands until they see ready, then either drop or
  // (continuous) present a fresh pair.
  task automatic upd();
    for (int i = 0; i < NREQ; i++) begin
      if (rv[i] && last_rdy[i]) begin
        if (cont[i]) new_ops(i);
        else rv[i] = 1'b0;
      end else if (rv[i] && $urandom_range(0, 99) < drop) begin
        rv[i] = 1'b0;
      end else if (!rv[i] && (cont[i] || $urandom_range(0, 99) < rate)) begin
        rv[i] = 1'b1;
        new_ops(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd();
  endtask

  task automatic do_reset();
    RST = 1'b1; rv = '0; cont = '0; rate = 0; drop = 0; zmix = 0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp, input string nm, output longint tg);
    bit got;
    got = 0;
    tg  = 0;
    for (int k = 0; k < 60; k++) begin
      if (!got) begin
        @(negedge clk);
        if (req_ready != '0) begin
          got = 1;
          tg  = longint'($time);
          chk(nm, 32'(req_ready), 32'(exp));
        end
        tick();
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 60 cycles (want %0h)", nm, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint tg, tp;
    int rsp1;

    // Reset state
    RST = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_product", 32'(rsp_product), 0);
    chk("rst_mul_active", 32'(mul_active), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mul_fp1", 32'(mul_fp1), 0);
    tick();
    RST = 1'b0;

    // Single op, 1.0 * 1.0
    rv = 4'b0001; f1[0] = 16'h3C00; f2[0] = 16'h3C00;
    @(negedge clk);
    chk("b_ready", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("b_active", 32'(mul_active), 1);
    repeat (16) tick();
    @(negedge clk);
    chk("b_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("b_rsp_product", 32'(rsp_product), 32'h1000);
    tick();

    // All four continuously valid
    do_reset();
    cont = 4'b1111;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    rv = 4'b1111;
    tp = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_grant(4'(1 << k), "c_grant", tg);
      if (k > 0) chk("c_period", 32'((tg - tp) / 10), 18);
      tp = tg;
    end

    // Requesters 0 and 2 continuously valid
    do_reset();
    cont = 4'b0101;
    new_ops(0);
    new_ops(2);
    rv = 4'b0101;
    for (int k = 0; k < 4; k++)
      wait_grant((k % 2 == 0) ? 4'b0001 : 4'b0100, "d_grant", tg);

    // Reset in WAIT cycle 5 discards the op and restores rr_ptr
    do_reset();
    rv = 4'b0001; new_ops(0);
    wait_grant(4'b0001, "e_grant0", tg);
    rv[1] = 1'b1; new_ops(1);
    wait_grant(4'b0010, "e_grant1", tg);
    repeat (6) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rv = 4'b0011; new_ops(0);
    @(negedge clk);
    chk("e_busy", 32'(busy), 0);
    chk("e_rsp_valid", 32'(rsp_valid), 0);
    chk("e_mul_active", 32'(mul_active), 0);
    chk("e_ptr_grant", 32'(req_ready), 32'h1);
    tick();
    wait_grant(4'b0010, "e_regrant", tg);

    // Zero-magnitude operand pair
    do_reset();
    rv = 4'b0001; f1[0] = 16'h8000; f2[0] = 16'h4000;
    @(negedge clk);
    chk("f_ready", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
`ifdef MUL_ARB_ZERO_BYPASS_EN
    chk("f_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("f_rsp_product", 32'(rsp_product), 0);
    chk("f_mul_active", 32'(mul_active), 0);
    tick();
`else
    chk("f_mul_active", 32'(mul_active), 1);
    repeat (16) tick();
    @(negedge clk);
    chk("f_rsp_valid", 32'(rsp_valid), 32'h1);
    tick();
`endif

    // Requester 1 withdraws at the cycle requester 0 is granted
    do_reset();
    new_ops(0);
    new_ops(1);
    rv = 4'b0011;
    @(negedge clk);
    chk("g_ready", 32'(req_ready), 32'h1);
    tick();
    rv[1] = 1'b0;
    rsp1 = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp1++;
      tick();
    end
    chk("g_no_rsp1", 32'(rsp1), 0);

    // Random traffic with withdrawals and occasional reset pulses
    do_reset();
    rate = 25; drop = 3; zmix = 1;
    repeat (3000) begin
      tick();
      RST = ($urandom_range(0, 599) == 0);
    end
    RST = 1'b0; rate = 0; drop = 0; rv = '0;
    repeat (25) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one multicycle FP16 multiplier.
REQ-002 Parameter LAT, default 15, SHALL set the multiplier busy cycles after its single-cycle active pulse.
REQ-003 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester operand-pair valid.
REQ-006 req_ready  out  NREQ  one-hot accept strobe.
REQ-007 req_fp1 / req_fp2  in  NREQ*16 each  packed FP16 operands, requester i at bits [16i+15:16i].
REQ-008 mul_active  out  1  start pulse to the multiplier.
REQ-009 mul_fp1 / mul_fp2  out  16 each  multiplier operands.
REQ-010 mul_product  in  13  multiplier result fraction.
REQ-011 mul_carry / mul_round_loss  in  1 each  multiplier carry-out and round-loss flags.
REQ-012 rsp_valid  out  NREQ  one-hot single-cycle response strobe to the owning requester.
REQ-013 rsp_product  out  13  registered result; rsp_carry and rsp_round_loss (1 each) are registered flags.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE with any req_valid: grant the round-robin winner starting at pointer rr_ptr, pulse req_ready[g] combinationally that cycle, latch its operands and g, go to ISSUE.
REQ-017 IDLE with no req_valid: stay in IDLE, all outputs quiet.
REQ-018 ISSUE: mul_active=1 for exactly one cycle, then WAIT with wait_cnt=0.
REQ-019 WAIT: wait_cnt increments each cycle; at wait_cnt==LAT-1 capture mul_product, mul_carry and mul_round_loss, go to RESP.
REQ-020 RESP: rsp_valid[g]=1 for one cycle, rr_ptr=(g+1) mod NREQ, return to IDLE.
REQ-021 Latency from accept cycle t to rsp_valid SHALL be LAT+2 cycles (t+17 at default).
REQ-022 Throughput SHALL be one operation per LAT+3 cycles, since the IDLE cycle is mandatory.
REQ-023 mul_fp1/mul_fp2 SHALL hold the latched operands from ISSUE through the end of WAIT, and be zero otherwise.
REQ-024 Requester owns the handshake: it holds req_valid and its operands until req_ready; req_valid dropped before grant is never served.
REQ-025 rsp_product and both rsp flags SHALL hold their value between responses.
REQ-026 wait_cnt SHALL be ceil(log2(LAT)) bits wide.

Reset
REQ-027 RST SHALL force IDLE, rr_ptr=0, wait_cnt=0, and all outputs to 0, including rsp_product, rsp flags, busy and mul_active, on the next edge.
REQ-028 RST mid-operation SHALL discard the in-flight operation with no rsp_valid; requesters re-request after release.

Configuration
REQ-029 Macro MUL_ARB_ZERO_BYPASS_EN defined: an accepted pair with either operand [14:0]==0 goes IDLE->RESP directly.
REQ-030 In that bypass case: result 0, flags 0, rsp_valid at t+1, mul_active never asserted.
REQ-031 Macro undefined: every pair takes the multiplier path with no bypass logic synthesized.

Structure
REQ-032 Package mul_arb_pkg SHALL hold the FSM state enum, the FP16 width (16) and the product width (13).
REQ-033 Sub-module mul_rr_pick SHALL be combinational: (req vector, rr_ptr) -> one-hot grant plus index.

Verification
REQ-034 Reset, req_valid=0001, fp1=0x3C00, fp2=0x3C00, model drives mul_product=13'h1000 -> req_ready=0001 at t, mul_active at t+1, rsp_valid=0001 and rsp_product=13'h1000 at t+17.
REQ-035 All four requesters valid from reset -> grants 0,1,2,3, rsp_valid every 18 cycles.
REQ-036 Requesters 0 and 2 continuously valid -> grant order strictly 0,2,0,2.
REQ-037 RST pulsed at WAIT cycle 5 -> next cycle IDLE, busy=0, no rsp_valid, rr_ptr=0; held request re-granted after release.
REQ-038 fp1=0x8000, fp2=0x4000 -> with macro rsp_valid at t+1, product 0, no mul_active; without macro rsp_valid at t+17.
REQ-039 req_valid[1] dropped at the cycle requester 0 is granted -> requester 1 never receives rsp_valid.
